// File: rtl/mcpu_core_hs_pkg.sv
// Shared definitions for the multicycle MIPS core: FSM states, opcodes, functs and ALU ops.
package mcpu_core_hs_pkg;

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StErr    = 3'd5
  } state_e;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpJal   = 6'h03;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddiu = 6'h09;
  localparam logic [5:0] OpOri   = 6'h0d;
  localparam logic [5:0] OpLui   = 6'h0f;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2b;

  localparam logic [5:0] FnSll  = 6'h00;
  localparam logic [5:0] FnJr   = 6'h08;
  localparam logic [5:0] FnAddu = 6'h21;
  localparam logic [5:0] FnSubu = 6'h23;
  localparam logic [5:0] FnAnd  = 6'h24;
  localparam logic [5:0] FnOr   = 6'h25;
  localparam logic [5:0] FnSlt  = 6'h2a;

  typedef enum logic [2:0] {
    AluAdd,
    AluSub,
    AluAnd,
    AluOr,
    AluSlt,
    AluSll,
    AluLui
  } alu_op_e;

  // True for every opcode/funct pair the core implements.
  function automatic logic is_legal(logic [5:0] op, logic [5:0] fn);
    logic ok;
    case (op)
      OpRtype: begin
        case (fn)
          FnSll, FnJr, FnAddu, FnSubu, FnAnd, FnOr, FnSlt: ok = 1'b1;
          default: ok = 1'b0;
        endcase
      end
      OpJ, OpJal, OpBeq, OpBne, OpAddiu, OpOri, OpLui, OpLw, OpSw: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // sll shifts the b operand (rt); lui takes the immediate from b[15:0].
  function automatic logic [31:0] alu_compute(alu_op_e op, logic [31:0] a, logic [31:0] b,
                                              logic [4:0] shamt);
    logic [31:0] res;
    case (op)
      AluAdd:  res = a + b;
      AluSub:  res = a - b;
      AluAnd:  res = a & b;
      AluOr:   res = a | b;
      AluSlt:  res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      AluSll:  res = b << shamt;
      AluLui:  res = {b[15:0], 16'h0000};
      default: res = a + b;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mcpu_rf.sv
// 32x32 register file: two asynchronous read ports, one synchronous write port, r0 reads zero.
module mcpu_rf (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  raddr_a,
  input  logic [4:0]  raddr_b,
  output logic [31:0] rdata_a,
  output logic [31:0] rdata_b,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata
);

  logic [31:0] regs_q [32];

  // Clear on reset; writes to r0 are dropped so its storage stays zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q <= '{default: '0};
    end else if (we && (waddr != 5'd0)) begin
      regs_q[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == 5'd0) ? 32'd0 : regs_q[raddr_a];
  assign rdata_b = (raddr_b == 5'd0) ? 32'd0 : regs_q[raddr_b];

endmodule

// File: rtl/mcpu_core_hs.sv
// Multicycle MIPS subset core on a single unified memory with a ready handshake and timeout.
module mcpu_core_hs #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rdy,
  output logic        err,
  output logic [31:0] pc_o,
  output logic [2:0]  state_o
);
  import mcpu_core_hs_pkg::*;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d;
  logic [31:0] alu_out_q, alu_out_d, mdr_q, mdr_d, wait_q, wait_d;

  logic [5:0]  op, fn;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm16;
  logic [31:0] sext_imm, zext_imm, ls_addr, alu_b, alu_res;
  logic        is_rtype, is_jr, is_load, is_store, is_branch, is_jump;
  logic        accept, mem_wait, timeout_hit;
  alu_op_e     alu_op;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, rf_rdata_a, rf_rdata_b;

  assign op       = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign shamt    = ir_q[10:6];
  assign fn       = ir_q[5:0];
  assign imm16    = ir_q[15:0];
  assign sext_imm = {{16{imm16[15]}}, imm16};
  assign zext_imm = {16'h0000, imm16};
  assign ls_addr  = a_q + sext_imm;

  assign is_rtype  = (op == OpRtype);
  assign is_jr     = is_rtype && (fn == FnJr);
  assign is_load   = (op == OpLw);
  assign is_store  = (op == OpSw);
  assign is_branch = (op == OpBeq) || (op == OpBne);
  assign is_jump   = (op == OpJ) || (op == OpJal);

  assign accept      = mem_req && mem_rdy;
  assign mem_wait    = mem_req && !mem_rdy;
  assign timeout_hit = (TIMEOUT != 0) && mem_wait && (wait_q == 32'(TIMEOUT - 1));

  mcpu_rf u_rf (
    .clk     (clk),
    .rst     (rst),
    .raddr_a (rs),
    .raddr_b (rt),
    .rdata_a (rf_rdata_a),
    .rdata_b (rf_rdata_b),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata)
  );

  // ALU operation and second operand selection from the latched instruction.
  always_comb begin
    alu_op = AluAdd;
    if (is_rtype) begin
      case (fn)
        FnSubu:  alu_op = AluSub;
        FnAnd:   alu_op = AluAnd;
        FnOr:    alu_op = AluOr;
        FnSlt:   alu_op = AluSlt;
        FnSll:   alu_op = AluSll;
        default: alu_op = AluAdd;
      endcase
    end else if (op == OpOri) begin
      alu_op = AluOr;
    end else if (op == OpLui) begin
      alu_op = AluLui;
    end
    alu_b   = is_rtype ? b_q : ((op == OpOri) || (op == OpLui)) ? zext_imm : sext_imm;
    alu_res = alu_compute(alu_op, a_q, alu_b, shamt);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= StFetch;
    else     state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch: begin
        if (accept)           state_d = StDecode;
        else if (timeout_hit) state_d = StErr;
      end
      StDecode: state_d = is_legal(op, fn) ? StExec : StErr;
      StExec: begin
        if (is_load || is_store)     state_d = (ls_addr[1:0] != 2'b00) ? StErr : StMem;
        else if (is_branch || is_jump) state_d = StFetch;
        else if (is_jr)              state_d = (a_q[1:0] != 2'b00) ? StErr : StFetch;
        else                         state_d = StWb;
      end
      StMem: begin
        if (accept)           state_d = is_store ? StFetch : StWb;
        else if (timeout_hit) state_d = StErr;
      end
      StWb:    state_d = StFetch;
      StErr:   state_d = StErr;
      default: state_d = StErr;
    endcase
  end

  // FSM outputs; memory is only driven in FETCH and MEM.
  always_comb begin
    mem_req   = (state_q == StFetch) || (state_q == StMem);
    mem_we    = (state_q == StMem) && is_store;
    mem_addr  = (state_q == StMem) ? alu_out_q : pc_q;
    mem_wdata = b_q;
    err       = (state_q == StErr);
    pc_o      = pc_q;
    state_o   = state_q;
  end

  // Datapath next-state and register file write control.
  always_comb begin
    pc_d      = pc_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    alu_out_d = alu_out_q;
    mdr_d     = mdr_q;
    wait_d    = mem_wait ? wait_q + 32'd1 : 32'd0;
    rf_we     = 1'b0;
    rf_waddr  = rd;
    rf_wdata  = alu_out_q;
    case (state_q)
      StFetch: begin
        if (accept) begin
          ir_d = mem_rdata;
          pc_d = pc_q + 32'd4;
        end
      end
      StDecode: begin
        a_d       = rf_rdata_a;
        b_d       = rf_rdata_b;
        alu_out_d = pc_q + {sext_imm[29:0], 2'b00};
      end
      StExec: begin
        if (is_load || is_store) begin
          alu_out_d = ls_addr;
        end else if (is_branch) begin
          if ((op == OpBeq) == (a_q == b_q)) pc_d = alu_out_q;
        end else if (is_jump) begin
          pc_d = {pc_q[31:28], ir_q[25:0], 2'b00};
          if (op == OpJal) begin
            rf_we    = 1'b1;
            rf_waddr = 5'd31;
            rf_wdata = pc_q;
          end
        end else if (is_jr) begin
          if (a_q[1:0] == 2'b00) pc_d = a_q;
        end else begin
          alu_out_d = alu_res;
        end
      end
      StMem: begin
        if (accept && is_load) mdr_d = mem_rdata;
      end
      StWb: begin
        rf_we    = 1'b1;
        rf_waddr = is_rtype ? rd : rt;
        rf_wdata = is_load ? mdr_q : alu_out_q;
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_out_q <= '0;
      mdr_q     <= '0;
      wait_q    <= '0;
    end else begin
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      alu_out_q <= alu_out_d;
      mdr_q     <= mdr_d;
      wait_q    <= wait_d;
    end
  end

endmodule

// File: tb/tb_mcpu_core_hs.sv
// Directed self-checking bench for mcpu_core_hs with a latency-configurable memory model.
module tb_mcpu_core_hs;

  localparam logic [31:0] RPC = 32'h0000_3000;

  localparam logic [5:0] OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04, OP_BNE = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09, OP_ORI = 6'h0d, OP_LUI = 6'h0f;
  localparam logic [5:0] OP_LW = 6'h23, OP_SW = 6'h2b;
  localparam logic [5:0] FN_SLL = 6'h00, FN_JR = 6'h08, FN_ADDU = 6'h21, FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND = 6'h24, FN_OR = 6'h25, FN_SLT = 6'h2a;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req, mem_we, err;
  logic [31:0] mem_addr, mem_wdata, pc_o;
  logic [31:0] mem_rdata = '0;
  logic        mem_rdy = 1'b0;
  logic [2:0]  state_o;

  always #5 clk = ~clk;

  mcpu_core_hs #(
    .RESET_PC (RPC),
    .TIMEOUT  (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_rdy   (mem_rdy),
    .err       (err),
    .pc_o      (pc_o),
    .state_o   (state_o)
  );

  logic [31:0] mem [0:16383];
  int          lat = 0;
  bit          hang = 1'b0;
  bit          stall_data = 1'b0;
  int          wcnt = 0;
  int          cyc = 0;
  int          req_cycles = 0;
  int          wr_count = 0;
  logic [31:0] last_waddr = '0;
  logic [31:0] last_wdata = '0;
  logic [31:0] f_addr [$];
  int          f_cyc [$];
  int          n_tests = 0;
  int          n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory responder: raises mem_rdy after lat wait cycles; logs accepted fetches.
  always @(negedge clk) begin
    if (rst || !mem_req) begin
      mem_rdy = 1'b0;
      wcnt    = 0;
    end else if (hang || (stall_data && (mem_addr < 32'h1000)) || (wcnt < lat)) begin
      mem_rdy = 1'b0;
      wcnt    = wcnt + 1;
    end else begin
      mem_rdy = 1'b1;
      wcnt    = 0;
      if (mem_we) begin
        mem[mem_addr[15:2]] = mem_wdata;
        wr_count   = wr_count + 1;
        last_waddr = mem_addr;
        last_wdata = mem_wdata;
      end else begin
        mem_rdata = mem[mem_addr[15:2]];
        if (state_o == 3'd0) begin
          f_addr.push_back(mem_addr);
          f_cyc.push_back(cyc);
        end
      end
    end
    if (mem_req && !rst) req_cycles = req_cycles + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests = n_tests + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(int rs, int rt, int rd, int sh, logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
  endfunction

  function automatic logic [31:0] enc_i(logic [5:0] op, int rs, int rt, logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  function automatic logic [31:0] enc_j(logic [5:0] op, logic [31:0] target);
    return {op, target[27:2]};
  endfunction

  function automatic logic [31:0] rf(int n);
    return dut.u_rf.regs_q[n];
  endfunction

  function automatic logic [31:0] faddr(int i);
    return (f_addr.size() > i) ? f_addr[i] : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] fdelta(int i);
    return (f_cyc.size() > i + 1) ? 32'(f_cyc[i+1] - f_cyc[i]) : 32'hFFFF_FFFF;
  endfunction

  task automatic put(int i, logic [31:0] w);
    mem[(RPC >> 2) + i] = w;
  endtask

  task automatic run(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Assert reset and clear memory and responder settings.
  task automatic begin_test();
    @(posedge clk);
    #1 rst = 1'b1;
    hang       = 1'b0;
    stall_data = 1'b0;
    lat        = 0;
    for (int i = 0; i < 16384; i++) mem[i] = '0;
  endtask

  task automatic release_reset();
    run(2);
    rst = 1'b0;
    f_addr.delete();
    f_cyc.delete();
    req_cycles = 0;
    wr_count   = 0;
  endtask

  initial begin
    // Straight-line ALU program, zero-wait memory.
    begin_test();
    put(0,  enc_i(OP_ADDIU, 0, 1, 16'd5));
    put(1,  enc_i(OP_ADDIU, 0, 2, 16'hFFFD));
    put(2,  enc_r(1, 2, 3, 0, FN_ADDU));
    put(3,  enc_r(1, 2, 8, 0, FN_SUBU));
    put(4,  enc_i(OP_LUI, 0, 5, 16'h1234));
    put(5,  enc_i(OP_ORI, 5, 5, 16'h8765));
    put(6,  enc_r(2, 1, 6, 0, FN_SLT));
    put(7,  enc_r(1, 2, 11, 0, FN_SLT));
    put(8,  enc_r(0, 1, 7, 4, FN_SLL));
    put(9,  enc_r(5, 1, 9, 0, FN_AND));
    put(10, enc_r(1, 7, 10, 0, FN_OR));
    put(11, enc_j(OP_J, RPC + 32'd44));
    run(2);
    check_eq("rst_pc", pc_o, RPC);
    check_eq("rst_state", 32'(state_o), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    release_reset();
    check_eq("first_req", 32'(mem_req), 32'd1);
    check_eq("first_addr", mem_addr, RPC);
    run(60);
    check_eq("r1", rf(1), 32'd5);
    check_eq("r2", rf(2), 32'hFFFF_FFFD);
    check_eq("addu_r3", rf(3), 32'd2);
    check_eq("subu_r8", rf(8), 32'd8);
    check_eq("lui_ori_r5", rf(5), 32'h1234_8765);
    check_eq("slt_true", rf(6), 32'd1);
    check_eq("slt_false", rf(11), 32'd0);
    check_eq("sll_r7", rf(7), 32'd80);
    check_eq("and_r9", rf(9), 32'd5);
    check_eq("or_r10", rf(10), 32'h55);
    check_eq("cyc_addiu1", fdelta(0), 32'd4);
    check_eq("cyc_addiu2", fdelta(1), 32'd4);
    check_eq("cyc_addu", fdelta(2), 32'd4);
    check_eq("alu_no_err", 32'(err), 32'd0);

    // Store then load with 3 wait cycles on every access.
    begin_test();
    put(0, enc_i(OP_ADDIU, 0, 3, 16'd2));
    put(1, enc_i(OP_SW, 0, 3, 16'd0));
    put(2, enc_i(OP_LW, 0, 4, 16'd0));
    put(3, enc_j(OP_J, RPC + 32'd12));
    mem[0] = 32'hDEAD_BEEF;
    lat = 3;
    run(2);
    check_eq("rf_cleared_by_rst", rf(3), 32'd0);
    release_reset();
    run(60);
    check_eq("sw_count", 32'(wr_count), 32'd1);
    check_eq("sw_addr", last_waddr, 32'd0);
    check_eq("sw_data", last_wdata, 32'd2);
    check_eq("lw_r4", rf(4), 32'd2);
    check_eq("cyc_lw", fdelta(2), 32'd11);

    // beq taken.
    begin_test();
    put(0, enc_i(OP_BEQ, 0, 0, 16'd2));
    put(1, enc_i(OP_ADDIU, 0, 1, 16'd1));
    put(3, enc_j(OP_J, RPC + 32'd12));
    release_reset();
    run(20);
    check_eq("beq_target", faddr(1), RPC + 32'd12);
    check_eq("cyc_beq", fdelta(0), 32'd3);
    check_eq("beq_skip_r1", rf(1), 32'd0);

    // bne not taken.
    begin_test();
    put(0, enc_i(OP_BNE, 0, 0, 16'd2));
    put(1, enc_j(OP_J, RPC + 32'd4));
    release_reset();
    run(20);
    check_eq("bne_fallthru", faddr(1), RPC + 32'd4);

    // jal / jr round trip, write to r0 discarded.
    begin_test();
    put(0, enc_j(OP_JAL, RPC + 32'd16));
    put(1, enc_i(OP_ADDIU, 0, 0, 16'd7));
    put(2, enc_j(OP_J, RPC + 32'd8));
    put(4, enc_r(31, 0, 0, 0, FN_JR));
    release_reset();
    run(30);
    check_eq("jal_r31", rf(31), RPC + 32'd4);
    check_eq("jal_target", faddr(1), RPC + 32'd16);
    check_eq("jr_return", faddr(2), RPC + 32'd4);
    check_eq("after_ret", faddr(3), RPC + 32'd8);
    check_eq("r0_zero", rf(0), 32'd0);
    check_eq("jal_no_err", 32'(err), 32'd0);

    // Fetch timeout with mem_rdy held low.
    begin_test();
    hang = 1'b1;
    release_reset();
    run(15);
    check_eq("to_not_yet", 32'(err), 32'd0);
    check_eq("to_still_fetch", 32'(state_o), 32'd0);
    run(1);
    check_eq("to_err", 32'(err), 32'd1);
    check_eq("to_req_low", 32'(mem_req), 32'd0);
    check_eq("to_state", 32'(state_o), 32'd5);
    check_eq("to_pc_frozen", pc_o, RPC);

    // Misaligned load: error, no data request.
    begin_test();
    put(0, enc_i(OP_LW, 0, 5, 16'd2));
    release_reset();
    run(10);
    check_eq("mis_err", 32'(err), 32'd1);
    check_eq("mis_req_cycles", 32'(req_cycles), 32'd1);
    check_eq("mis_pc", pc_o, RPC + 32'd4);

    // Illegal opcode: error two cycles after release.
    begin_test();
    put(0, 32'hFC00_0000);
    release_reset();
    run(2);
    check_eq("ill_err", 32'(err), 32'd1);
    run(3);
    check_eq("ill_sticky", 32'(err), 32'd1);

    // Reset during a stalled MEM access.
    begin_test();
    put(0, enc_i(OP_LW, 0, 5, 16'd0));
    mem[0] = 32'h0000_0055;
    stall_data = 1'b1;
    release_reset();
    run(6);
    check_eq("stall_in_mem", 32'(state_o), 32'd3);
    check_eq("stall_addr", mem_addr, 32'd0);
    rst = 1'b1;
    run(1);
    check_eq("abort_state", 32'(state_o), 32'd0);
    check_eq("abort_pc", pc_o, RPC);
    rst = 1'b0;
    check_eq("abort_req", 32'(mem_req), 32'd1);
    check_eq("abort_fetch_addr", mem_addr, RPC);
    check_eq("abort_r5", rf(5), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
